// File: rtl/regfile_scoreboard.sv
// Architectural register file with same-cycle write bypass and a per-register
// pending-load scoreboard that stalls decode on load-use hazards.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                RegWrite_In,
  input  logic [4:0]          WriteReg_In,
  input  logic [DATA_W-1:0]   WriteData_In,
  input  logic [4:0]          ReadReg1_In,
  input  logic [4:0]          ReadReg2_In,
  output logic [DATA_W-1:0]   ReadData1_Out,
  output logic [DATA_W-1:0]   ReadData2_Out,
  input  logic                LoadIssue_In,
  input  logic [4:0]          LoadDest_In,
  output logic                Stall_Out,
  output logic [NUM_REGS-1:0] Pending_Out,
  output logic [CNT_W-1:0]    WriteCount_Out
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic wr_eff;
  logic bypass1, bypass2;

  assign wr_eff  = RegWrite_In && (WriteReg_In != 5'd0);
  assign bypass1 = wr_eff && (WriteReg_In == ReadReg1_In);
  assign bypass2 = wr_eff && (WriteReg_In == ReadReg2_In);

  always_comb begin
    ReadData1_Out = '0;
    if (ReadReg1_In != 5'd0)
      ReadData1_Out = bypass1 ? WriteData_In : regs_q[ReadReg1_In];
  end

  always_comb begin
    ReadData2_Out = '0;
    if (ReadReg2_In != 5'd0)
      ReadData2_Out = bypass2 ? WriteData_In : regs_q[ReadReg2_In];
  end

  // pend_q[0] is never set, so reading index 0 can never stall.
  assign Stall_Out = (pend_q[ReadReg1_In] && !bypass1) ||
                     (pend_q[ReadReg2_In] && !bypass2);

  // Clear first, then set, so a newly issued load to the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_eff)
      pend_d[WriteReg_In] = 1'b0;
    if (LoadIssue_In && !Stall_Out && (LoadDest_In != 5'd0))
      pend_d[LoadDest_In] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_eff && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Index 0 is never written, so its entry holds the reset value of zero.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else if (wr_eff) begin
      regs_q[WriteReg_In] <= WriteData_In;
    end
  end

  assign Pending_Out    = pend_q;
  assign WriteCount_Out = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector bench for regfile_scoreboard: table of per-cycle inputs and
// expected outputs, plus hand sequences for counter saturation and mid-run reset.
module tb_regfile_scoreboard;

  logic        Clk;
  logic        Rst_n;
  logic        RegWrite_In;
  logic [4:0]  WriteReg_In;
  logic [31:0] WriteData_In;
  logic [4:0]  ReadReg1_In;
  logic [4:0]  ReadReg2_In;
  logic [31:0] ReadData1_Out;
  logic [31:0] ReadData2_Out;
  logic        LoadIssue_In;
  logic [4:0]  LoadDest_In;
  logic        Stall_Out;
  logic [31:0] Pending_Out;
  logic [15:0] WriteCount_Out;

  regfile_scoreboard dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .RegWrite_In    (RegWrite_In),
    .WriteReg_In    (WriteReg_In),
    .WriteData_In   (WriteData_In),
    .ReadReg1_In    (ReadReg1_In),
    .ReadReg2_In    (ReadReg2_In),
    .ReadData1_Out  (ReadData1_Out),
    .ReadData2_Out  (ReadData2_Out),
    .LoadIssue_In   (LoadIssue_In),
    .LoadDest_In    (LoadDest_In),
    .Stall_Out      (Stall_Out),
    .Pending_Out    (Pending_Out),
    .WriteCount_Out (WriteCount_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        li;
    logic [4:0]  ld;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic        exp_stall;
    logic [31:0] exp_pend;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vec [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge; outputs settle before the next rise.
  task automatic drive(input logic rst_n, input logic we, input logic [4:0] wreg,
                       input logic [31:0] wdata, input logic [4:0] r1, input logic [4:0] r2,
                       input logic li, input logic [4:0] ld);
    @(negedge Clk);
    Rst_n        = rst_n;
    RegWrite_In  = we;
    WriteReg_In  = wreg;
    WriteData_In = wdata;
    ReadReg1_In  = r1;
    ReadReg2_In  = r2;
    LoadIssue_In = li;
    LoadDest_In  = ld;
    #2;
  endtask

  initial begin
    //         rst we wreg wdata         r1  r2  li ld   rd1           rd2    stall pend         cnt
    vec[0]  = '{0, 0, 0,  32'h0,        5,  31, 0, 0,  32'h0,        32'h0,  0, 32'h0,      16'd0};
    vec[1]  = '{1, 1, 7,  32'hDEADBEEF, 7,  0,  0, 0,  32'hDEADBEEF, 32'h0,  0, 32'h0,      16'd0};
    vec[2]  = '{1, 0, 0,  32'h0,        7,  7,  0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h0, 16'd1};
    vec[3]  = '{1, 1, 0,  32'h12345678, 0,  0,  1, 0,  32'h0,        32'h0,  0, 32'h0,      16'd1};
    vec[4]  = '{1, 0, 0,  32'h0,        0,  7,  0, 0,  32'h0,        32'hDEADBEEF, 0, 32'h0, 16'd1};
    vec[5]  = '{1, 0, 0,  32'h0,        7,  0,  1, 4,  32'hDEADBEEF, 32'h0,  0, 32'h0,      16'd1};
    vec[6]  = '{1, 0, 0,  32'h0,        7,  4,  0, 0,  32'hDEADBEEF, 32'h0,  1, 32'h10,     16'd1};
    vec[7]  = '{1, 1, 4,  32'h55,       7,  4,  0, 0,  32'hDEADBEEF, 32'h55, 0, 32'h10,     16'd1};
    vec[8]  = '{1, 0, 0,  32'h0,        0,  4,  0, 0,  32'h0,        32'h55, 0, 32'h0,      16'd2};
    vec[9]  = '{1, 0, 0,  32'h0,        0,  0,  1, 9,  32'h0,        32'h0,  0, 32'h0,      16'd2};
    vec[10] = '{1, 1, 9,  32'hAA,       0,  0,  1, 9,  32'h0,        32'h0,  0, 32'h200,    16'd2};
    vec[11] = '{1, 0, 0,  32'h0,        9,  0,  1, 10, 32'hAA,       32'h0,  1, 32'h200,    16'd3};
    vec[12] = '{1, 0, 0,  32'h0,        9,  0,  0, 0,  32'hAA,       32'h0,  1, 32'h200,    16'd3};
    vec[13] = '{1, 0, 0,  32'h0,        0,  9,  0, 0,  32'h0,        32'hAA, 1, 32'h200,    16'd3};

    // Two reset cycles bring every state bit to a known value before checking.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vec[i].rst_n, vec[i].we, vec[i].wreg, vec[i].wdata,
            vec[i].r1, vec[i].r2, vec[i].li, vec[i].ld);
      check($sformatf("v%0d rd1", i), ReadData1_Out, vec[i].exp_rd1);
      check($sformatf("v%0d rd2", i), ReadData2_Out, vec[i].exp_rd2);
      check($sformatf("v%0d stall", i), {31'b0, Stall_Out}, {31'b0, vec[i].exp_stall});
      check($sformatf("v%0d pend", i), Pending_Out, vec[i].exp_pend);
      check($sformatf("v%0d cnt", i), {16'b0, WriteCount_Out}, {16'b0, vec[i].exp_cnt});
      $display("vec %0d: rd1=%h rd2=%h stall=%b pend=%h cnt=%0d",
               i, ReadData1_Out, ReadData2_Out, Stall_Out, Pending_Out, WriteCount_Out);
    end

    // Counter saturation: 3 writes already counted, then 65540 more.
    for (int i = 0; i < 65540; i++) begin
      drive(1, 1, 5'((i % 31) + 1), i, 0, 0, 0, 0);
      if (i == 65529)
        check("cnt before saturation", {16'b0, WriteCount_Out}, 32'd65532);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("cnt saturated", {16'b0, WriteCount_Out}, 32'h0000FFFF);
    $display("saturation: cnt=%h", WriteCount_Out);

    // Leave a pending load, then reset while writing R3 and issuing another load.
    drive(1, 0, 0, 0, 0, 0, 1, 12);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("pend before reset", Pending_Out, 32'h1000);
    drive(0, 1, 3, 32'h123, 0, 0, 1, 5);
    drive(1, 0, 0, 0, 3, 12, 0, 0);
    check("R3 after reset", ReadData1_Out, 32'h0);
    check("R12 after reset", ReadData2_Out, 32'h0);
    check("cnt after reset", {16'b0, WriteCount_Out}, 32'h0);
    check("pend after reset", Pending_Out, 32'h0);
    check("stall after reset", {31'b0, Stall_Out}, 32'h0);
    $display("mid-run reset: rd1=%h cnt=%0d pend=%h", ReadData1_Out, WriteCount_Out, Pending_Out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
